gf180mcu_fd_sc_mcu9t5v0__oai211_bist: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__oai211_bist_if.sv | 22 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__oai211_bist.sv | 90 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai211_bist.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai211_bist_if.sv
// gf180mcu_fd_sc_mcu9t5v0__oai211_bist_if: run control, cell drive/observe and result signals of the oai211 BIST
interface gf180mcu_fd_sc_mcu9t5v0__oai211_bist_if;
  logic START;
  logic ZN;
  logic A1;
  logic A2;
  logic B;
  logic C;
  logic BUSY;
  logic DONE;
  logic PASS;
  logic [4:0] ERR_CNT;
  logic [3:0] FAIL_VEC;
  modport master (
    input  START, ZN,
    output A1, A2, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
  );
  modport slave (
    output START, ZN,
    input  A1, A2, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai211_bist.sv
// gf180mcu_fd_sc_mcu9t5v0__oai211_bist: exhaustive 16-vector sweep of an oai211 cell with pass/fail, error count and first failing vector.
// Define OAI211_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module gf180mcu_fd_sc_mcu9t5v0__oai211_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS = 1
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu9t5v0__oai211_bist_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [3:0] SC = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LL = 4'(LOOPS - 1);
  state_t state_q, state_d;
  logic [3:0] vec_q, vec_d, set_q, set_d, loop_q, loop_d, fvec_q, fvec_d;
  logic [4:0] err_q, err_d;
  logic exp_zn, cap, mis;
  logic pwr_unused;
  assign pwr_unused = VDD ^ VSS;
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      vec_q   <= '0;
      set_q   <= '0;
      loop_q  <= '0;
      fvec_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      set_q   <= set_d;
      loop_q  <= loop_d;
      fvec_q  <= fvec_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    set_d   = set_q;
    loop_d  = loop_q;
    fvec_d  = fvec_q;
    err_d   = err_q;
    exp_zn  = ~((vec_q[3] | vec_q[2]) & vec_q[1] & vec_q[0]);
    cap     = (state_q == RUN) && (set_q == SC);
    // if/else so an unknown ZN falls into the mismatch branch
    if (bus.ZN == exp_zn) mis = 1'b0;
    else mis = 1'b1;
    if (state_q != RUN) begin
      if (bus.START) begin
        state_d = RUN;
        vec_d   = '0;
        set_d   = '0;
        loop_d  = '0;
        fvec_d  = '0;
        err_d   = '0;
      end
    end else if (!cap) begin
      set_d = set_q + 4'd1;
    end else begin
      set_d = '0;
      if (mis) begin
        err_d  = (err_q == 5'd31) ? err_q : err_q + 5'd1;
        fvec_d = (err_q == 5'd0) ? vec_q : fvec_q;
      end
      vec_d = (vec_q == 4'd15) ? 4'd0 : vec_q + 4'd1;
      if (vec_q == 4'd15) begin
        if (loop_q < LL) loop_d = loop_q + 4'd1;
        else state_d = FIN;
      end
`ifdef OAI211_BIST_STOP_ON_FAIL_EN
      if (mis) begin
        state_d = FIN;
        vec_d   = '0;
      end
`endif
    end
  end
  assign bus.A1       = vec_q[3];
  assign bus.A2       = vec_q[2];
  assign bus.B        = vec_q[1];
  assign bus.C        = vec_q[0];
  assign bus.BUSY     = state_q == RUN;
  assign bus.DONE     = state_q == FIN;
  assign bus.PASS     = (state_q == FIN) && (err_q == 5'd0);
  assign bus.ERR_CNT  = err_q;
  assign bus.FAIL_VEC = fvec_q;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai211_bist.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__oai211_bist: directed runs of the oai211 BIST against good and stuck cell models
module tb_gf180mcu_fd_sc_mcu9t5v0__oai211_bist;
`ifdef OAI211_BIST_STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif
  typedef struct {
    int sel;
    int mode;
    int pulse;
    int err;
    int fvec;
    int pass;
    int cyc;
  } row_t;
  logic CLK = 1'b0;
  logic RN = 1'b0;
  wire vdd = 1'b1;
  wire vss = 1'b0;
  int mode = 0;
  int sel = 0;
  logic st0 = 1'b0, st1 = 1'b0;
  int checks = 0, errors = 0;
  gf180mcu_fd_sc_mcu9t5v0__oai211_bist_if b0();
  gf180mcu_fd_sc_mcu9t5v0__oai211_bist_if b1();
  gf180mcu_fd_sc_mcu9t5v0__oai211_bist #(.SETTLE_CYCLES(2), .LOOPS(1)) u0 (
    .CLK(CLK), .RN(RN), .VDD(vdd), .VSS(vss), .bus(b0));
  gf180mcu_fd_sc_mcu9t5v0__oai211_bist #(.SETTLE_CYCLES(2), .LOOPS(3)) u1 (
    .CLK(CLK), .RN(RN), .VDD(vdd), .VSS(vss), .bus(b1));
  always #5 CLK = ~CLK;
  // mode 0: good cell, 1: ZN stuck-at-1, 2: ZN stuck-at-0
  assign b0.ZN = (mode == 0) ? ~((b0.A1 | b0.A2) & b0.B & b0.C) : (mode == 1);
  assign b1.ZN = (mode == 0) ? ~((b1.A1 | b1.A2) & b1.B & b1.C) : (mode == 1);
  assign b0.START = st0;
  assign b1.START = st1;
  logic [3:0] a_s, fv_s;
  logic [4:0] err_s;
  logic busy_s, done_s, pass_s;
  always_comb begin
    a_s    = (sel != 0) ? {b1.A1, b1.A2, b1.B, b1.C} : {b0.A1, b0.A2, b0.B, b0.C};
    fv_s   = (sel != 0) ? b1.FAIL_VEC : b0.FAIL_VEC;
    err_s  = (sel != 0) ? b1.ERR_CNT : b0.ERR_CNT;
    busy_s = (sel != 0) ? b1.BUSY : b0.BUSY;
    done_s = (sel != 0) ? b1.DONE : b0.DONE;
    pass_s = (sel != 0) ? b1.PASS : b0.PASS;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic set_start(input logic v);
    if (sel != 0) st1 = v;
    else st0 = v;
  endtask
  task automatic run_row(input row_t r);
    int n;
    int bad_n;
    logic [3:0] ev;
    sel = r.sel;
    mode = r.mode;
    @(negedge CLK);
    set_start(1'b1);
    @(posedge CLK);
    @(negedge CLK);
    set_start(1'b0);
    n = 0;
    bad_n = -1;
    chk("start_busy", busy_s, 1);
    chk("start_done", done_s, 0);
    chk("start_err", err_s, 0);
    chk("start_fvec", fv_s, 0);
    while (!done_s && n < 400) begin
      ev = 4'((n / 3) % 16);
      if (busy_s && a_s != ev && bad_n < 0) bad_n = n;
      if (n == r.pulse) set_start(1'b1);
      if (n == r.pulse + 1) set_start(1'b0);
      @(negedge CLK);
      n++;
    end
    chk("vec_seq_first_bad_cycle", bad_n, -1);
    chk("done_cycle", n, r.cyc);
    chk("fin_busy", busy_s, 0);
    chk("fin_err", err_s, r.err);
    chk("fin_fvec", fv_s, r.fvec);
    chk("fin_pass", pass_s, r.pass);
    chk("fin_vec_zero", a_s, 0);
    repeat (4) @(negedge CLK);
    chk("hold_done", done_s, 1);
    chk("hold_err", err_s, r.err);
  endtask
  row_t tbl[6];
  initial begin
    tbl[0] = '{0, 0, -1, 0, 0, 1, 48};
    tbl[1] = '{0, 0, 10, 0, 0, 1, 48};
    tbl[2] = '{0, 1, -1, SOF ? 1 : 3, 7, 0, SOF ? 24 : 48};
    tbl[3] = '{0, 2, -1, SOF ? 1 : 13, 0, 0, SOF ? 3 : 48};
    tbl[4] = '{1, 2, -1, SOF ? 1 : 31, 0, 0, SOF ? 3 : 144};
    tbl[5] = '{1, 0, -1, 0, 0, 1, 144};
    repeat (2) @(negedge CLK);
    chk("rst_vec", a_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_pass", pass_s, 0);
    chk("rst_err", err_s, 0);
    chk("rst_fvec", fv_s, 0);
    RN = 1'b1;
    @(negedge CLK);
    chk("idle_busy", busy_s, 0);
    for (int i = 0; i < 6; i++) run_row(tbl[i]);
    sel = 0;
    mode = 2;
    @(negedge CLK);
    st0 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    st0 = 1'b0;
    repeat (19) @(negedge CLK);
    RN = 1'b0;
    #1;
    chk("abort_vec", a_s, 0);
    chk("abort_busy", busy_s, 0);
    chk("abort_done", done_s, 0);
    chk("abort_pass", pass_s, 0);
    chk("abort_err", err_s, 0);
    chk("abort_fvec", fv_s, 0);
    @(negedge CLK);
    RN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_abort_idle", busy_s | done_s, 0);
    run_row(tbl[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
